tug_referee: RTL and testbench

- Round and match controller for the 9-LED tug-of-war playfield.
- Turns the player keys into single-cycle, arbitrated move pulses for the light chain.
- Watches the LED vector to detect a win and keeps per-player scores.
- After each round it holds the result, clears the playfield, and stops the match once a player reaches the target score.

---
 rtl/tug_referee_if.sv | 36 +++
 rtl/tug_referee.sv | 173 +++++++++++++++++
 tb/tb_tug_referee.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tug_referee_if.sv
// ---------------------------------------------------------------------------
// tug_referee_if
// Bundles the playfield-facing signals of the tug-of-war referee.
//   key_l / key_r : player key levels, synchronized to clk, 1 = pressed
//   led[9:1]      : current playfield lights, led[9] is the leftmost
//   L / R         : one-cycle move pulses toward the left / right
//   field_reset   : one-cycle pulse that clears the playfield
//   winner        : 00 none, 01 right, 10 left
//   score_l/_r    : per-player scores
//   match_over    : high once a player has reached the target score
// master = key/playfield side, slave = referee.
// ---------------------------------------------------------------------------
interface tug_referee_if #(
  parameter int SCORE_W = 3
);
  logic               key_l;
  logic               key_r;
  logic [9:1]         led;
  logic               L;
  logic               R;
  logic               field_reset;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               match_over;

  modport master (
    output key_l, key_r, led,
    input  L, R, field_reset, winner, score_l, score_r, match_over
  );

  modport slave (
    input  key_l, key_r, led,
    output L, R, field_reset, winner, score_l, score_r, match_over
  );
endinterface

// File: rtl/tug_referee.sv
// ---------------------------------------------------------------------------
// tug_referee
// Round and match controller for the 9-LED tug-of-war playfield. Converts
// key presses into arbitrated single-cycle move pulses, detects a win when a
// player presses while the light sits on their end, keeps scores, displays
// the winner for HOLD_CYCLES, clears the field, and stops at SCORE_MAX.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : tug_referee_if.slave (keys, led in; L, R, field_reset, winner,
//           score_l, score_r, match_over out; all outputs registered)
// ---------------------------------------------------------------------------
module tug_referee #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int SCORE_W     = 3,
  parameter int SCORE_MAX   = 7
) (
  input  logic          clk,
  input  logic          reset,
  tug_referee_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_HOLD,
    ST_CLEAR,
    ST_OVER
  } state_e;

  state_e             state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic               key_l_q,       key_l_d;
  logic               key_r_q,       key_r_d;
  logic               l_q,           l_d;
  logic               r_q,           r_d;
  logic               field_reset_q, field_reset_d;
  logic [1:0]         winner_q,      winner_d;
  logic [SCORE_W-1:0] score_l_q,     score_l_d;
  logic [SCORE_W-1:0] score_r_q,     score_r_d;
  logic               match_over_q,  match_over_d;

  logic press_l;
  logic press_r;

  // Only the two end lights decide a win; the middle of the field is ignored.
  logic unused_led_mid;
  assign unused_led_mid = ^bus.led[8:2];

  assign press_l = bus.key_l & ~key_l_q;
  assign press_r = bus.key_r & ~key_r_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_l_d       = bus.key_l;
    key_r_d       = bus.key_r;
    l_d           = 1'b0;
    r_d           = 1'b0;
    field_reset_d = 1'b0;
    winner_d      = winner_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    match_over_d  = match_over_q;

    unique case (state_q)
      ST_PLAY: begin
        // A simultaneous press by both players is a tie and is dropped.
        if (press_l && !press_r) begin
          if (bus.led[9]) begin
            score_l_d = score_l_q + 1'b1;
            winner_d  = WIN_LEFT;
            if (score_l_d == SCORE_TOP) begin
              state_d      = ST_OVER;
              match_over_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end else begin
            l_d = 1'b1;
          end
        end else if (press_r && !press_l) begin
          if (bus.led[1]) begin
            score_r_d = score_r_q + 1'b1;
            winner_d  = WIN_RIGHT;
            if (score_r_d == SCORE_TOP) begin
              state_d      = ST_OVER;
              match_over_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end else begin
            r_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // field_reset is raised on entry so it is high throughout CLEAR.
        if (cnt_q == CNT_LAST) begin
          state_d       = ST_CLEAR;
          field_reset_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLEAR: begin
        winner_d = WIN_NONE;
        cnt_d    = '0;
        state_d  = ST_PLAY;
      end

      ST_OVER: begin
        // Terminal until reset: everything holds, the field is left as is.
      end

      default: state_d = ST_PLAY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      cnt_q         <= '0;
      // Loading the live key levels means a key held through reset is not
      // seen as a fresh press.
      key_l_q       <= bus.key_l;
      key_r_q       <= bus.key_r;
      l_q           <= 1'b0;
      r_q           <= 1'b0;
      field_reset_q <= 1'b0;
      winner_q      <= WIN_NONE;
      score_l_q     <= '0;
      score_r_q     <= '0;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_l_q       <= key_l_d;
      key_r_q       <= key_r_d;
      l_q           <= l_d;
      r_q           <= r_d;
      field_reset_q <= field_reset_d;
      winner_q      <= winner_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      match_over_q  <= match_over_d;
    end
  end

  assign bus.L           = l_q;
  assign bus.R           = r_q;
  assign bus.field_reset = field_reset_q;
  assign bus.winner      = winner_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.match_over  = match_over_q;

endmodule

// File: tb/tb_tug_referee.sv
// ---------------------------------------------------------------------------
// tb_tug_referee
// Self-checking bench for tug_referee with HOLD_CYCLES=4, SCORE_MAX=3.
// Directed scenarios use constant expectations; a randomized run compares
// every cycle against an event model that tracks rounds by clock-edge number.
// ---------------------------------------------------------------------------
module tb_tug_referee;

  localparam int HOLD = 4;
  localparam int SW   = 3;
  localparam int SMAX = 3;

  localparam logic [9:1] LED_C     = 9'b000010000;
  localparam logic [9:1] LED_LEFT  = 9'b100000000;
  localparam logic [9:1] LED_RIGHT = 9'b000000001;

  logic clk = 1'b0;
  logic rst;

  tug_referee_if #(.SCORE_W(SW)) bus ();

  tug_referee #(
    .HOLD_CYCLES(HOLD),
    .SCORE_W    (SW),
    .SCORE_MAX  (SMAX)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model (edge-numbered round tracking) --------
  int         n_edge   = 0;
  bit         m_prev_l = 1'b0;
  bit         m_prev_r = 1'b0;
  int         m_sl     = 0;
  int         m_sr     = 0;
  logic [1:0] m_win    = 2'b00;
  bit         m_over   = 1'b0;
  bit         m_L      = 1'b0;
  bit         m_R      = 1'b0;
  bit         m_fr     = 1'b0;
  bit         m_ending = 1'b0;
  int         m_win_edge = 0;

  // Expected outputs after the coming clock edge, from the inputs now applied.
  task automatic model_step();
    bit pl;
    bit pr;
    n_edge++;
    m_L  = 1'b0;
    m_R  = 1'b0;
    m_fr = 1'b0;
    if (rst) begin
      m_prev_l = bus.key_l;
      m_prev_r = bus.key_r;
      m_sl     = 0;
      m_sr     = 0;
      m_win    = 2'b00;
      m_over   = 1'b0;
      m_ending = 1'b0;
    end else begin
      pl = bus.key_l && !m_prev_l;
      pr = bus.key_r && !m_prev_r;
      m_prev_l = bus.key_l;
      m_prev_r = bus.key_r;
      if (m_over) begin
        // frozen
      end else if (m_ending) begin
        // Winner shown for HOLD edges, field cleared on the next, play after.
        if (n_edge == m_win_edge + HOLD) m_fr = 1'b1;
        else if (n_edge == m_win_edge + HOLD + 1) begin
          m_win    = 2'b00;
          m_ending = 1'b0;
        end
      end else if (pl && pr) begin
        // tie
      end else if (pl) begin
        if (bus.led[9]) begin
          m_sl++;
          m_win = 2'b10;
          if (m_sl == SMAX) m_over = 1'b1;
          else begin
            m_ending   = 1'b1;
            m_win_edge = n_edge;
          end
        end else m_L = 1'b1;
      end else if (pr) begin
        if (bus.led[1]) begin
          m_sr++;
          m_win = 2'b01;
          if (m_sr == SMAX) m_over = 1'b1;
          else begin
            m_ending   = 1'b1;
            m_win_edge = n_edge;
          end
        end else m_R = 1'b1;
      end
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    bus.key_l = 1'b1;
    bus.key_r = 1'b0;
    bus.led   = LED_C;
    tick();
    checks++;
    if ({bus.L, bus.R, bus.field_reset, bus.winner, bus.score_l, bus.score_r, bus.match_over} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: L=%b R=%b fr=%b winner=%b sl=%0d sr=%0d mo=%b, expected all 0",
               bus.L, bus.R, bus.field_reset, bus.winner, bus.score_l, bus.score_r, bus.match_over);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.L !== 1'b0) begin
      failures++;
      $display("FAIL reset_key_held: L=%b, expected 0 (key held through reset)", bus.L);
    end
    bus.key_l = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    int l_cnt = 0;
    int r_cnt = 0;
    do_reset();
    bus.led = LED_C;
    repeat (9) tick();
    bus.key_l = 1'b1;
    tick();
    checks++;
    if (bus.L !== 1'b1 || bus.R !== 1'b0) begin
      failures++;
      $display("FAIL press_pulse: L=%b R=%b, expected L=1 R=0", bus.L, bus.R);
    end
    for (int i = 1; i < 20; i++) begin
      tick();
      if (bus.L) l_cnt++;
      if (bus.R) r_cnt++;
    end
    checks++;
    if (l_cnt != 0 || r_cnt != 0) begin
      failures++;
      $display("FAIL press_single: extra L=%0d R=%0d, expected 0 0", l_cnt, r_cnt);
    end
    bus.key_l = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    bus.led = LED_C;
    tick();
    bus.key_l = 1'b1;
    bus.key_r = 1'b1;
    tick();
    checks++;
    if ({bus.L, bus.R, bus.score_l, bus.score_r} !== '0) begin
      failures++;
      $display("FAIL tie_discard: L=%b R=%b sl=%0d sr=%0d, expected all 0",
               bus.L, bus.R, bus.score_l, bus.score_r);
    end
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    tick();
    bus.key_r = 1'b1;
    tick();
    checks++;
    if (bus.R !== 1'b1 || bus.L !== 1'b0) begin
      failures++;
      $display("FAIL tie_then_r: L=%b R=%b, expected L=0 R=1", bus.L, bus.R);
    end
    bus.key_r = 1'b0;
    tick();
  endtask

  task automatic test_left_win();
    int early = 0;
    do_reset();
    bus.led = LED_LEFT;
    tick();
    bus.key_l = 1'b1;
    tick();
    checks++;
    if (bus.L !== 1'b0 || bus.winner !== 2'b10 || bus.score_l !== 3'd1) begin
      failures++;
      $display("FAIL left_win: L=%b winner=%b sl=%0d, expected L=0 winner=10 sl=1",
               bus.L, bus.winner, bus.score_l);
    end
    bus.key_l = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      if (bus.field_reset) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL hold_no_clear: field_reset seen %0d times during hold, expected 0", early);
    end
    tick();
    checks++;
    if (bus.field_reset !== 1'b1 || bus.winner !== 2'b10) begin
      failures++;
      $display("FAIL clear_pulse: fr=%b winner=%b, expected fr=1 winner=10", bus.field_reset, bus.winner);
    end
    tick();
    checks++;
    if (bus.field_reset !== 1'b0 || bus.winner !== 2'b00) begin
      failures++;
      $display("FAIL after_clear: fr=%b winner=%b, expected fr=0 winner=00", bus.field_reset, bus.winner);
    end
  endtask

  task automatic test_right_win_held();
    int fr_cnt = 0;
    int r_cnt  = 0;
    do_reset();
    bus.led = LED_RIGHT;
    tick();
    bus.key_r = 1'b1;
    tick();
    checks++;
    if (bus.score_r !== 3'd1 || bus.winner !== 2'b01 || bus.R !== 1'b0) begin
      failures++;
      $display("FAIL right_win: R=%b winner=%b sr=%0d, expected R=0 winner=01 sr=1",
               bus.R, bus.winner, bus.score_r);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.field_reset) fr_cnt++;
      if (bus.R) r_cnt++;
    end
    checks++;
    if (fr_cnt != 1 || r_cnt != 0 || bus.score_r !== 3'd1) begin
      failures++;
      $display("FAIL right_held: fr pulses=%0d R pulses=%0d sr=%0d, expected 1 0 1",
               fr_cnt, r_cnt, bus.score_r);
    end
    bus.led   = LED_C;
    bus.key_r = 1'b0;
    tick();
    bus.key_r = 1'b1;
    tick();
    checks++;
    if (bus.R !== 1'b1) begin
      failures++;
      $display("FAIL right_new_edge: R=%b, expected 1", bus.R);
    end
    bus.key_r = 1'b0;
    tick();
  endtask

  task automatic test_match_over();
    int bad = 0;
    do_reset();
    for (int w = 1; w <= SMAX; w++) begin
      bus.led   = LED_LEFT;
      bus.key_l = 1'b1;
      tick();
      checks++;
      if (bus.score_l !== SW'(w)) begin
        failures++;
        $display("FAIL match_score: sl=%0d, expected %0d", bus.score_l, w);
      end
      bus.key_l = 1'b0;
      if (w < SMAX) repeat (HOLD + 1) tick();
    end
    checks++;
    if (bus.match_over !== 1'b1 || bus.winner !== 2'b10 || bus.score_l !== 3'd3) begin
      failures++;
      $display("FAIL match_over: mo=%b winner=%b sl=%0d, expected 1 10 3",
               bus.match_over, bus.winner, bus.score_l);
    end
    for (int i = 0; i < 12; i++) begin
      bus.led   = (i % 3 == 0) ? LED_LEFT : ((i % 3 == 1) ? LED_RIGHT : LED_C);
      bus.key_l = ~bus.key_l;
      bus.key_r = (i % 2 == 0);
      tick();
      if (bus.L || bus.R || bus.field_reset || bus.winner !== 2'b10 || bus.match_over !== 1'b1
          || bus.score_l !== 3'd3 || bus.score_r !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL over_frozen: %0d cycles changed after match end, expected 0", bad);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.L, bus.R, bus.field_reset, bus.winner, bus.score_l, bus.score_r, bus.match_over} !== '0) begin
      failures++;
      $display("FAIL over_reset: winner=%b sl=%0d mo=%b, expected all 0",
               bus.winner, bus.score_l, bus.match_over);
    end
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    tick();
  endtask

  task automatic test_reset_during_hold();
    int fr_cnt = 0;
    do_reset();
    bus.led   = LED_LEFT;
    bus.key_l = 1'b1;
    tick();
    bus.key_l = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.field_reset, bus.winner, bus.score_l, bus.score_r, bus.match_over} !== '0) begin
      failures++;
      $display("FAIL hold_abort: fr=%b winner=%b sl=%0d, expected 0 00 0",
               bus.field_reset, bus.winner, bus.score_l);
    end
    bus.led = LED_C;
    repeat (HOLD + 3) begin
      tick();
      if (bus.field_reset) fr_cnt++;
    end
    checks++;
    if (fr_cnt != 0) begin
      failures++;
      $display("FAIL hold_abort_fr: field_reset pulses=%0d, expected 0", fr_cnt);
    end
    bus.key_l = 1'b1;
    tick();
    checks++;
    if (bus.L !== 1'b1) begin
      failures++;
      $display("FAIL hold_abort_play: L=%b, expected 1 (back in play)", bus.L);
    end
    bus.key_l = 1'b0;
    tick();
  endtask

  // ---------------- randomized run against the model ----------------------
  task automatic test_random();
    logic [14:0] got;
    logic [14:0] exp;
    int          sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.key_l = ~bus.key_l;
      if ($urandom_range(0, 3) == 0) bus.key_r = ~bus.key_r;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      bus.led = LED_LEFT;
      else if (sel < 6) bus.led = LED_RIGHT;
      else if (sel < 8) bus.led = 9'b1 << $urandom_range(0, 8);
      else              bus.led = 9'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      tick();
      got = {bus.L, bus.R, bus.field_reset, bus.winner, bus.score_l, bus.score_r, bus.match_over};
      exp = {m_L, m_R, m_fr, m_win, SW'(m_sl), SW'(m_sr), m_over};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_cycle %0d: {L,R,fr,win,sl,sr,mo}=%b, expected %b", c, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.key_l = 1'b0;
    bus.key_r = 1'b0;
    bus.led   = LED_C;
    test_reset();
    test_single_press();
    test_tie();
    test_left_win();
    test_right_win_held();
    test_match_over();
    test_reset_during_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
